// File: rtl/ir_tx_nec_mq.sv
// NEC infrared transmitter: first-word-fall-through request queue, 32-bit LSB-first frames,
// repeat frames, a fixed frame period and a gated carrier on the registered envelope.
module ir_tx_nec_mq #(
  parameter int UNIT_CYC    = 28125,
  parameter int CAR_DIV     = 1316,
  parameter int CAR_HIGH    = 439,
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_UNITS = 192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  cmd,
  input  logic        ext_addr,
  input  logic        wr,
  input  logic        repeat_en,
  output logic        full,
  output logic        ovf,
  output logic        busy,
  output logic        env_out,
  output logic        ir_out,
  output logic        frame_done,
  output logic [2:0]  state
);
  localparam int PW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int CW = (CAR_DIV > 1) ? $clog2(CAR_DIV) : 1;
  localparam int FW = $clog2(FRAME_UNITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LEAD_H = 3'd1, S_LEAD_L = 3'd2, S_BIT_H = 3'd3,
    S_BIT_L = 3'd4, S_STOP = 3'd5, S_GAP = 3'd6, S_RPT_L = 3'd7
  } state_t;

  logic [24:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          empty, push, pop, ovf_q;
  logic [24:0]   head;
  logic [31:0]   payload;

  state_t        state_q, state_d;
  logic [3:0]    uc_q, uc_d;
  logic [4:0]    bit_q, bit_d;
  logic [31:0]   sh_q, sh_d;
  logic          rpt_q, rpt_d;
  logic [PW-1:0] pc_q;
  logic [FW-1:0] ft_q;
  logic [CW-1:0] car_q;
  logic          tick, fstart, gap_end, env_d;
  logic          env_q, ir_q, fd_q;

  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = wr & ~full;   // a full queue drops the write even when it pops this cycle
  assign head  = mem_q[rp_q];
  assign payload = {~head[7:0], head[7:0],
                    head[24] ? head[23:16] : ~head[15:8], head[15:8]};

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {ext_addr, addr, cmd};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      ovf_q <= wr & full;
    end
  end

  assign tick = (pc_q == PW'(UNIT_CYC - 1));

  always_comb begin
    state_d = state_q;
    uc_d    = tick ? uc_q + 4'd1 : uc_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rpt_d   = rpt_q;
    pop     = 1'b0;
    fstart  = 1'b0;
    gap_end = 1'b0;
    env_d   = 1'b0;
    case (state_q)
      S_IDLE: if (!empty) begin
        pop = 1'b1; fstart = 1'b1; rpt_d = 1'b0; sh_d = payload; state_d = S_LEAD_H;
      end
      S_LEAD_H: begin
        env_d = 1'b1;
        if (tick && uc_q == 4'd15) state_d = rpt_q ? S_RPT_L : S_LEAD_L;
      end
      S_LEAD_L: if (tick && uc_q == 4'd7) begin
        state_d = S_BIT_H; bit_d = '0;
      end
      S_BIT_H: begin
        env_d = 1'b1;
        if (tick) state_d = S_BIT_L;
      end
      S_BIT_L: if (tick && uc_q == (sh_q[0] ? 4'd2 : 4'd0)) begin
        sh_d = {1'b0, sh_q[31:1]};
        if (bit_q == 5'd31) state_d = S_STOP;
        else begin
          state_d = S_BIT_H; bit_d = bit_q + 5'd1;
        end
      end
      S_RPT_L: if (tick && uc_q == 4'd3) state_d = S_STOP;
      S_STOP: begin
        env_d = 1'b1;
        if (tick) state_d = S_GAP;
      end
      S_GAP: if (tick && ft_q == FW'(FRAME_UNITS - 1)) begin
        // queued data always wins over a repeat frame
        gap_end = 1'b1;
        if (!empty) begin
          pop = 1'b1; fstart = 1'b1; rpt_d = 1'b0; sh_d = payload; state_d = S_LEAD_H;
        end else if (repeat_en) begin
          fstart = 1'b1; rpt_d = 1'b1; state_d = S_LEAD_H;
        end else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q || fstart) uc_d = '0;
  end

  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      uc_q    <= '0;
      bit_q   <= '0;
      rpt_q   <= 1'b0;
      pc_q    <= '0;
      ft_q    <= '0;
      car_q   <= '0;
      env_q   <= 1'b0;
      ir_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      uc_q    <= uc_d;
      bit_q   <= bit_d;
      rpt_q   <= rpt_d;
      pc_q    <= (fstart || tick) ? '0 : pc_q + PW'(1);
      if (fstart) ft_q <= '0;
      else if (state_q != S_IDLE && tick) ft_q <= ft_q + FW'(1);
      car_q   <= (fstart || car_q == CW'(CAR_DIV - 1)) ? '0 : car_q + CW'(1);
      env_q   <= env_d;
      ir_q    <= env_d & (car_q < CW'(CAR_HIGH));
      fd_q    <= gap_end;
    end
  end

  assign ovf        = ovf_q;
  assign busy       = (state_q != S_IDLE);
  assign env_out    = env_q;
  assign ir_out     = ir_q;
  assign frame_done = fd_q;
  assign state      = state_q;
endmodule
